// File: rtl/pipe_pkg.sv
// Shared screen bounds, reset values, gap limits, LFSR seed and FSM encoding
// for the pipe obstacle controller.
package pipe_pkg;

    localparam int SCR_X_MIN = 144;
    localparam int SCR_X_MAX = 784;
    localparam int SCR_Y_MIN = 35;
    localparam int SCR_Y_MAX = 514;

    localparam logic [9:0] PIPE0_X_RST = 10'd600;
    localparam logic [9:0] PIPE1_X_RST = 10'd920;
    localparam logic [9:0] GAP_TOP_RST = 10'd200;

    localparam int GAP_MIN = 75;
    localparam int GAP_MAX = 330;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // Fixed gap-top sequence used when the random-gap build option is off.
    function automatic logic [9:0] gap_table(input logic [1:0] idx);
        case (idx)
            2'd0:    return 10'd100;
            2'd1:    return 10'd180;
            2'd2:    return 10'd260;
            default: return 10'(GAP_MAX);
        endcase
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) stepping every clk; only built when
// PIPE_RANDOM_GAP_EN is defined.
`ifdef PIPE_RANDOM_GAP_EN
module lfsr8
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= LFSR_SEED;
        else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
endmodule
`endif

// File: rtl/pipe_controller.sv
// Two-pipe obstacle controller: scrolling, gap selection, collision and scoring.
// Build option PIPE_RANDOM_GAP_EN: LFSR-driven gap tops instead of the fixed table.
module pipe_controller
    import pipe_pkg::*;
#(
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 120,
    parameter int SPEED     = 2,
    parameter int SPACING   = 320,
    parameter int BIRD_HALF = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] bird_x,
    input  logic [9:0] bird_y,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       bright,
    output logic       pipe_fill,
    output logic       collision,
    output logic       game_over,
    output logic [7:0] score
);
    localparam logic [10:0] PW       = 11'(PIPE_W);
    localparam logic [10:0] GH       = 11'(GAP_H);
    localparam logic [10:0] SP       = 11'(SPEED);
    localparam logic [10:0] SPC      = 11'(SPACING);
    localparam logic [10:0] BH       = 11'(BIRD_HALF);
    localparam logic [10:0] X_MIN    = 11'(SCR_X_MIN);
    localparam logic [10:0] X_MAX    = 11'(SCR_X_MAX);
    localparam logic [10:0] FLOOR    = 11'(SCR_Y_MAX);
    localparam logic [10:0] WRAP_LIM = 11'(SCR_X_MIN - PIPE_W + SPEED);

    state_t      state_q, state_d;
    logic [9:0]  pipe0_x, pipe1_x, gap0, gap1;
    logic [9:0]  pipe0_x_d, pipe1_x_d, gap0_d, gap1_d;
    logic [9:0]  gap_new0, gap_new1;
    logic [7:0]  score_q, score_d;
    logic [8:0]  score_sum;
    logic [10:0] x0, x1, g0, g1, bx, by, hc, vc, nx0, nx1;
    logic        wrap0, wrap1, pass0, pass1;
    logic        hit0, hit1, hit, fill0, fill1;

    // One guard bit so the wrap test and edge sums can never underflow/overflow.
    assign x0 = {1'b0, pipe0_x};
    assign x1 = {1'b0, pipe1_x};
    assign g0 = {1'b0, gap0};
    assign g1 = {1'b0, gap1};
    assign bx = {1'b0, bird_x};
    assign by = {1'b0, bird_y};
    assign hc = {1'b0, hCount};
    assign vc = {1'b0, vCount};

    assign fill0     = (hc >= x0) && (hc < x0 + PW) && ((vc < g0) || (vc >= g0 + GH));
    assign fill1     = (hc >= x1) && (hc < x1 + PW) && ((vc < g1) || (vc >= g1 + GH));
    assign pipe_fill = bright && (hc >= X_MIN) && (hc < X_MAX) && (fill0 || fill1);

    assign hit0 = (bx + BH >= x0) && (bx < x0 + PW + BH) && ((by < g0 + BH) || (by + BH >= g0 + GH));
    assign hit1 = (bx + BH >= x1) && (bx < x1 + PW + BH) && ((by < g1 + BH) || (by + BH >= g1 + GH));
    assign hit  = hit0 || hit1 || (by + BH >= FLOOR);

    // pipe1 resolves first so a simultaneous wrap places pipe0 behind pipe1's new spot.
    assign wrap0 = x0 < WRAP_LIM;
    assign wrap1 = x1 < WRAP_LIM;
    assign nx1   = wrap1 ? x0 + SPC : x1 - SP;
    assign nx0   = wrap0 ? (wrap1 ? nx1 : x1) + SPC : x0 - SP;

    assign pass0     = (x0 + PW >= bx) && (nx0 + PW < bx);
    assign pass1     = (x1 + PW >= bx) && (nx1 + PW < bx);
    assign score_sum = {1'b0, score_q} + {8'd0, pass0} + {8'd0, pass1};

`ifdef PIPE_RANDOM_GAP_EN
    logic [7:0] lfsr_q;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign gap_new1 = 10'(GAP_MIN) + {2'b00, lfsr_q};
    assign gap_new0 = gap_new1;
`else
    logic [1:0] gap_idx;

    assign gap_new1 = gap_table(gap_idx);
    assign gap_new0 = gap_table(wrap1 ? gap_idx + 2'd1 : gap_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 gap_idx <= 2'd0;
        else if (state_q == RUN) gap_idx <= gap_idx + {1'b0, wrap0} + {1'b0, wrap1};
    end
`endif

    always_comb begin
        state_d   = state_q;
        pipe0_x_d = pipe0_x;
        pipe1_x_d = pipe1_x;
        gap0_d    = gap0;
        gap1_d    = gap1;
        score_d   = score_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                pipe0_x_d = nx0[9:0];
                pipe1_x_d = nx1[9:0];
                if (wrap0) gap0_d = gap_new0;
                if (wrap1) gap1_d = gap_new1;
                score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
                // Entering DEAD on the same edge that latches collision.
                if (hit) state_d = DEAD;
            end
            DEAD:    state_d = DEAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe0_x   <= PIPE0_X_RST;
            pipe1_x   <= PIPE1_X_RST;
            gap0      <= GAP_TOP_RST;
            gap1      <= GAP_TOP_RST;
            score_q   <= '0;
            collision <= 1'b0;
        end else begin
            pipe0_x <= pipe0_x_d;
            pipe1_x <= pipe1_x_d;
            gap0    <= gap0_d;
            gap1    <= gap1_d;
            score_q <= score_d;
            if (state_q == RUN) collision <= hit;
        end
    end

    assign game_over = (state_q == DEAD);
    assign score     = score_q;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed scoreboard bench for pipe_controller (default fixed-gap build).
module tb_pipe_controller;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, bright;
    logic [9:0] bird_x, bird_y, hCount, vCount;
    logic       pipe_fill, collision, game_over;
    logic [7:0] score;

    pipe_controller #(
        .PIPE_W    (40),
        .GAP_H     (120),
        .SPEED     (2),
        .SPACING   (320),
        .BIRD_HALF (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bird_x    (bird_x),
        .bird_y    (bird_y),
        .hCount    (hCount),
        .vCount    (vCount),
        .bright    (bright),
        .pipe_fill (pipe_fill),
        .collision (collision),
        .game_over (game_over),
        .score     (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0; int x1; int g0; int g1; int sc; int col; int ov;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_st, m_x0, m_x1, m_g0, m_g1, m_sc, m_col, m_idx;
    int   gap_seq[4] = '{100, 180, 260, 330};
    int   ph[8] = '{600, 600, 600, 600, 639, 640, 599, 700};
    int   pv[8] = '{100, 200, 319, 320, 450, 450, 450, 450};
    int   pb[8] = '{1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_x0 = 600; m_x1 = 920; m_g0 = 200; m_g1 = 200;
        m_sc = 0; m_col = 0; m_idx = 0;
        sb.delete();
    endtask

    function automatic bit mhit(input int x, input int g);
        int bx = int'(bird_x);
        int by = int'(bird_y);
        return (bx + 5 >= x) && (bx - 5 <= x + 39) && ((by - 5 < g) || (by + 5 > g + 119));
    endfunction

    function automatic bit pix_model();
        int h = int'(hCount);
        int v = int'(vCount);
        bit p0 = (h >= m_x0) && (h < m_x0 + 40) && ((v < m_g0) || (v >= m_g0 + 120));
        bit p1 = (h >= m_x1) && (h < m_x1 + 40) && ((v < m_g1) || (v >= m_g1 + 120));
        return bright && (h >= 144) && (h < 784) && (p0 || p1);
    endfunction

    task automatic model_step();
        int n0, n1, ev, bx;
        bit w0, w1, h;
        bx = int'(bird_x);
        if (m_st == 1) begin
            h  = mhit(m_x0, m_g0) || mhit(m_x1, m_g1) || (int'(bird_y) + 5 >= 514);
            w0 = (m_x0 - 2) < 104;
            w1 = (m_x1 - 2) < 104;
            n1 = w1 ? m_x0 + 320 : m_x1 - 2;
            n0 = w0 ? (w1 ? n1 : m_x1) + 320 : m_x0 - 2;
            ev = 0;
            if ((m_x0 + 40 >= bx) && (n0 + 40 < bx)) ev++;
            if ((m_x1 + 40 >= bx) && (n1 + 40 < bx)) ev++;
            if (w1) begin m_g1 = gap_seq[m_idx]; m_idx = (m_idx + 1) % 4; end
            if (w0) begin m_g0 = gap_seq[m_idx]; m_idx = (m_idx + 1) % 4; end
            m_sc  = (m_sc + ev > 255) ? 255 : m_sc + ev;
            m_x0  = n0;
            m_x1  = n1;
            m_col = h;
            if (h) m_st = 2;
        end else if (m_st == 0 && start) begin
            m_st = 1;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        e = '{m_x0, m_x1, m_g0, m_g1, m_sc, m_col, (m_st == 2) ? 1 : 0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pipe0_x", int'(dut.pipe0_x), e.x0);
        check("pipe1_x", int'(dut.pipe1_x), e.x1);
        check("gap0", int'(dut.gap0), e.g0);
        check("gap1", int'(dut.gap1), e.g1);
        check("score", int'(score), e.sc);
        check("collision", int'(collision), e.col);
        check("game_over", int'(game_over), e.ov);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bright = 1'b0;
        bird_x = 10'd300; bird_y = 10'd260; hCount = '0; vCount = '0;
        model_reset();
        #2;
        check("rst_x0", int'(dut.pipe0_x), 600);
        check("rst_x1", int'(dut.pipe1_x), 920);
        check("rst_gap0", int'(dut.gap0), 200);
        check("rst_score", int'(score), 0);
        check("rst_collision", int'(collision), 0);
        check("rst_game_over", int'(game_over), 0);
        #10;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            hCount = 10'(ph[i]); vCount = 10'(pv[i]); bright = pb[i][0];
            #1;
            check("pipe_fill", int'(pipe_fill), int'(pix_model()));
        end
        bright = 1'b0;

        repeat (50) tick();
        check("idle_state", int'(dut.state_q), int'(IDLE));
        check("idle_x0", int'(dut.pipe0_x), 600);
        check("idle_score", int'(score), 0);

        start = 1'b1;
        tick();
        check("run_state", int'(dut.state_q), int'(RUN));
        repeat (170) tick();
        check("pre_pass_x0", int'(dut.pipe0_x), 260);
        check("pre_pass_score", int'(score), 0);
        tick();
        check("pass_x0", int'(dut.pipe0_x), 258);
        check("pass_score", int'(score), 1);
        repeat (77) tick();
        check("pre_wrap_x0", int'(dut.pipe0_x), 104);
        tick();
        check("wrap_x0", int'(dut.pipe0_x), 744);
        check("wrap_x1", int'(dut.pipe1_x), 422);
        check("wrap_gap0", int'(dut.gap0), 100);
        check("wrap_collision", int'(collision), 0);
        repeat (11) tick();

        bird_x = 10'd740; bird_y = 10'd100;
        tick();
        check("pipe_hit_collision", int'(collision), 1);
        check("pipe_hit_game_over", int'(game_over), 1);
        repeat (10) tick();
        check("dead_x0_frozen", int'(dut.pipe0_x), 720);
        check("dead_score_held", int'(score), 1);

        rst = 1'b1;
        #1;
        check("async_rst_x0", int'(dut.pipe0_x), 600);
        check("async_rst_score", int'(score), 0);
        check("async_rst_game_over", int'(game_over), 0);
        model_reset();
        #3;
        rst = 1'b0;

        bird_x = 10'd300; bird_y = 10'd510; start = 1'b1;
        tick();
        tick();
        check("floor_collision", int'(collision), 1);
        check("floor_game_over", int'(game_over), 1);
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("dead_rst_x0", int'(dut.pipe0_x), 600);
        check("dead_rst_x1", int'(dut.pipe1_x), 920);
        check("dead_rst_collision", int'(collision), 0);
        check("dead_rst_game_over", int'(game_over), 0);
        check("dead_rst_state", int'(dut.state_q), int'(IDLE));
        model_reset();
        #2;
        rst = 1'b0;

        bird_y = 10'd270;
        tick();
        tick();
        force dut.pipe0_x = 10'd261;
        force dut.pipe1_x = 10'd261;
        force dut.score_q = 8'd254;
        #1;
        release dut.pipe0_x;
        release dut.pipe1_x;
        release dut.score_q;
        m_x0 = 261; m_x1 = 261; m_sc = 254;
        tick();
        check("sat_score", int'(score), 255);
        check("sat_x0", int'(dut.pipe0_x), 259);
        repeat (3) tick();
        check("sat_hold", int'(score), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
